bcast_dispatcher: RTL and testbench
===================================

Name: bcast_dispatcher

Overview:
- Request-side counterpart of the broadcast response collector. Accepts one broadcast packet plus a channel mask per handshake and fans the packet out to every masked AiM channel over independent per-channel valid/ready links.
- Announces each broadcast to the collector through bcast_add/bcast_mask, and stops accepting new broadcasts while the collector reports bcast_pipe_full.
- Sits between the host-side command decoder and the per-channel AiM controllers.

Parameters:
- CH_NUM, 32, number of AiM channels (≥2).
- PKT_WIDTH, 64, broadcast packet payload width in bits.
- STALL_LIMIT, 1024, cycles without any channel progress before stall_err sets (≥2).
- CNT_WIDTH, 32, width of the issued-broadcast counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset: asynchronous, active-high
- req_valid  input  1  broadcast request valid
- req_ready  output  1  broadcast request accepted when high together with req_valid
- req_pkt  input  PKT_WIDTH  broadcast packet payload
- req_mask  input  CH_NUM  target channels; bit i = channel i
- ch_valid  output  CH_NUM  per-channel packet valid
- ch_ready  input  CH_NUM  per-channel ready
- ch_pkt  output  PKT_WIDTH  latched packet, shared by all channels
- bcast_add  output  1  one-cycle pulse to the collector, new broadcast registered
- bcast_mask  output  CH_NUM  mask accompanying bcast_add
- bcast_pipe_full  input  1  collector full; blocks acceptance
- busy  output  1  dispatch in progress
- mask_err  output  1  one-cycle pulse, zero-mask request dropped
- stall_err  output  1  sticky, no channel progress for STALL_LIMIT cycles
- issued_cnt  output  CNT_WIDTH  count of broadcasts announced to the collector; wraps

Behaviour:
- State: pending[CH_NUM] register. busy = |pending. ch_valid = pending, driven directly from the register.
- ch_pkt register: loads req_pkt on accept; holds its value otherwise.
- Channel handshake:
  - pending[i] clears in the cycle after ch_valid[i] && ch_ready[i].
  - Channels complete in any order.
  - ch_valid[i] never drops before its handshake.
  - ch_pkt is stable while busy.
- done_now = busy && ((pending & ~ch_ready) == 0), i.e. the last outstanding channels handshake this cycle.
- req_ready = (!busy || done_now) && !bcast_pipe_full. It is combinational, so back-to-back broadcasts issue with zero bubble.
- accept = req_valid && req_ready.
  - Nonzero mask: pending <= req_mask, and this value overrides the clears from done_now.
  - bcast_add = accept && |req_mask, same cycle as accept; bcast_mask = req_mask.
  - The collector therefore records the mask before any channel can respond.
- Zero mask: the request is accepted and dropped. mask_err pulses for one cycle. No bcast_add, no channel activity, issued_cnt unchanged.
- bcast_pipe_full high: req_ready stays low. A dispatch already in flight continues unaffected.
- issued_cnt increments on every bcast_add; it wraps 2^CNT_WIDTH−1 → 0.
- Stall watchdog:
  - Counter resets to 0 when !busy, or when any ch_valid&ch_ready occurs.
  - It increments each busy cycle without a handshake.
  - On reaching STALL_LIMIT−1 and incrementing, stall_err sets and stays set until rst. Dispatch keeps running.
- Reset values, asserted at rst (asynchronous): pending=0, so ch_valid=0 and busy=0; ch_pkt=0; issued_cnt=0; stall counter=0; stall_err=0.
- Combinational outputs with rst high (inputs idle): bcast_add=0, mask_err=0, req_ready=!bcast_pipe_full.
- Reset mid-dispatch: ch_valid drops immediately with no handshake. The collector is reset by the same rst, so its state stays consistent.
- Payload integrity: ch_pkt equals the req_pkt captured at accept for every channel of that broadcast.

Test Plan:
- CH_NUM=4. Accept mask=4'b1011, pkt=0xA5. All ch_ready=1 → ch_valid=1011 for exactly 1 cycle; bcast_add=1 with bcast_mask=1011 at accept; issued_cnt=1; next request accepted on the completion cycle.
- Mask=1111, ch_ready staggered: ch0 at t+1, ch2 at t+3, ch1 at t+5, ch3 at t+7 → req_ready stays low until t+7; ch_pkt stable throughout; a second request is accepted at t+7 with no bubble.
- bcast_pipe_full=1 while req_valid=1, idle → req_ready=0 and no bcast_add; deassert full → accept in the same cycle.
- Mask=0 → req_ready=1, mask_err pulses, bcast_add=0, ch_valid=0, issued_cnt unchanged.
- STALL_LIMIT=8, mask=0001, ch_ready=0 → stall_err rises after the 8th stalled cycle. Then ch_ready=1 → dispatch completes and stall_err stays 1.
- Assert rst with pending=0110 mid-dispatch → ch_valid=0 asynchronously, issued_cnt=0, stall_err=0; the first post-reset accept behaves as in scenario 1.

Source files
------------

// File: rtl/bcast_dispatcher.sv
// Broadcast dispatcher: latches one packet + channel mask per handshake and fans it
// out to every masked channel over independent valid/ready links, announcing it to the collector.
module bcast_dispatcher #(
  parameter int CH_NUM      = 32,
  parameter int PKT_WIDTH   = 64,
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PKT_WIDTH-1:0] req_pkt,
  input  logic [CH_NUM-1:0]    req_mask,
  output logic [CH_NUM-1:0]    ch_valid,
  input  logic [CH_NUM-1:0]    ch_ready,
  output logic [PKT_WIDTH-1:0] ch_pkt,
  output logic                 bcast_add,
  output logic [CH_NUM-1:0]    bcast_mask,
  input  logic                 bcast_pipe_full,
  output logic                 busy,
  output logic                 mask_err,
  output logic                 stall_err,
  output logic [CNT_WIDTH-1:0] issued_cnt
);

  localparam int SC_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  logic [CH_NUM-1:0] pending;
  logic [SC_W-1:0]   stall_cnt;
  logic              done_now;
  logic              accept;
  logic              any_hs;

  // ch_valid comes straight from the register so it can never glitch or drop early.
  assign ch_valid   = pending;
  assign busy       = |pending;
  assign any_hs     = |(pending & ch_ready);
  assign done_now   = busy && ((pending & ~ch_ready) == '0);
  assign req_ready  = (!busy || done_now) && !bcast_pipe_full;
  assign accept     = req_valid && req_ready;
  assign bcast_add  = accept && (|req_mask);
  assign bcast_mask = req_mask;
  assign mask_err   = accept && !(|req_mask);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (bcast_add) begin
      // A new broadcast overrides the clears of the one completing this cycle.
      pending <= req_mask;
    end else begin
      pending <= pending & ~ch_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_pkt <= '0;
    end else if (accept) begin
      ch_pkt <= req_pkt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt <= '0;
    end else if (bcast_add) begin
      issued_cnt <= issued_cnt + CNT_WIDTH'(1);
    end
  end

  // Watchdog: counts busy cycles with no handshake; saturates once the error is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (!busy || any_hs) begin
      stall_cnt <= '0;
    end else if (stall_cnt == SC_W'(STALL_LIMIT - 1)) begin
      stall_err <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_bcast_dispatcher.sv
// Directed self-checking bench for bcast_dispatcher (4 channels, short stall limit,
// narrow issued counter so the wrap is reachable).
module tb_bcast_dispatcher;

  localparam int CH  = 4;
  localparam int PW  = 16;
  localparam int SL  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_pkt;
  logic [CH-1:0] req_mask;
  logic [CH-1:0] ch_valid;
  logic [CH-1:0] ch_ready;
  logic [PW-1:0] ch_pkt;
  logic          bcast_add;
  logic [CH-1:0] bcast_mask;
  logic          bcast_pipe_full;
  logic          busy;
  logic          mask_err;
  logic          stall_err;
  logic [CW-1:0] issued_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bcast_dispatcher #(
    .CH_NUM(CH), .PKT_WIDTH(PW), .STALL_LIMIT(SL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pkt(req_pkt), .req_mask(req_mask),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_pkt(ch_pkt),
    .bcast_add(bcast_add), .bcast_mask(bcast_mask), .bcast_pipe_full(bcast_pipe_full),
    .busy(busy), .mask_err(mask_err), .stall_err(stall_err), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [CH-1:0] stag_rdy [7];
  logic [CH-1:0] stag_pend[7];

  initial begin
    stag_rdy  = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
    stag_pend = '{4'b1111, 4'b1110, 4'b1110, 4'b1010, 4'b1010, 4'b1000, 4'b1000};

    rst = 1'b1; req_valid = 1'b0; req_pkt = '0; req_mask = '0;
    ch_ready = '0; bcast_pipe_full = 1'b0;
    #3;
    // Reset state and combinational outputs while in reset.
    check("rst_ch_valid", 32'(ch_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ch_pkt", 32'(ch_pkt), 0);
    check("rst_issued", 32'(issued_cnt), 0);
    check("rst_stall_err", 32'(stall_err), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_bcast_add", 32'(bcast_add), 0);
    check("rst_mask_err", 32'(mask_err), 0);
    bcast_pipe_full = 1'b1; #1;
    check("rst_req_ready_full", 32'(req_ready), 0);
    bcast_pipe_full = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Scenario 1: mask 1011, all ready, back-to-back follow-up on completion cycle.
    req_valid = 1'b1; req_mask = 4'b1011; req_pkt = 16'h00A5; ch_ready = 4'b1111; #1;
    check("s1_req_ready", 32'(req_ready), 1);
    check("s1_bcast_add", 32'(bcast_add), 1);
    check("s1_bcast_mask", 32'(bcast_mask), 32'b1011);
    step();
    check("s1_ch_valid", 32'(ch_valid), 32'b1011);
    check("s1_ch_pkt", 32'(ch_pkt), 32'h00A5);
    check("s1_issued", 32'(issued_cnt), 1);
    check("s1_busy", 32'(busy), 1);
    req_mask = 4'b0110; req_pkt = 16'h003C; #1;
    check("s1_ready_on_done", 32'(req_ready), 1);
    check("s1_add_on_done", 32'(bcast_add), 1);
    step();
    check("s1_ch_valid_2nd", 32'(ch_valid), 32'b0110);
    check("s1_ch_pkt_2nd", 32'(ch_pkt), 32'h003C);
    check("s1_issued_2nd", 32'(issued_cnt), 2);
    req_valid = 1'b0;
    step();
    check("s1_idle", 32'(ch_valid), 0);
    check("s1_idle_busy", 32'(busy), 0);

    // Scenario 2: mask 1111 with staggered readies; second request waits until t+7.
    req_valid = 1'b1; req_mask = 4'b1111; req_pkt = 16'h005A; ch_ready = 4'b0000;
    step();
    req_mask = 4'b0001; req_pkt = 16'h0077;
    for (int k = 0; k < 7; k++) begin
      ch_ready = stag_rdy[k]; #1;
      check($sformatf("s2_ch_valid_t%0d", k + 1), 32'(ch_valid), 32'(stag_pend[k]));
      check($sformatf("s2_ch_pkt_t%0d", k + 1), 32'(ch_pkt), 32'h005A);
      check($sformatf("s2_req_ready_t%0d", k + 1), 32'(req_ready), (k == 6) ? 1 : 0);
      check($sformatf("s2_bcast_add_t%0d", k + 1), 32'(bcast_add), (k == 6) ? 1 : 0);
      step();
    end
    check("s2_next_ch_valid", 32'(ch_valid), 32'b0001);
    check("s2_next_ch_pkt", 32'(ch_pkt), 32'h0077);
    check("s2_issued", 32'(issued_cnt), 4);
    req_valid = 1'b0; ch_ready = 4'b1111;
    step();
    check("s2_idle", 32'(ch_valid), 0);

    // Scenario 3: collector full blocks acceptance; release accepts in the same cycle.
    bcast_pipe_full = 1'b1; req_valid = 1'b1; req_mask = 4'b0011; req_pkt = 16'h0011;
    ch_ready = 4'b0000; #1;
    check("s3_ready_full", 32'(req_ready), 0);
    check("s3_add_full", 32'(bcast_add), 0);
    step();
    check("s3_no_dispatch", 32'(ch_valid), 0);
    check("s3_issued_held", 32'(issued_cnt), 4);
    bcast_pipe_full = 1'b0; #1;
    check("s3_ready_release", 32'(req_ready), 1);
    check("s3_add_release", 32'(bcast_add), 1);
    step();
    check("s3_ch_valid", 32'(ch_valid), 32'b0011);
    check("s3_issued", 32'(issued_cnt), 5);
    // In-flight dispatch completes while the collector reports full.
    bcast_pipe_full = 1'b1; req_valid = 1'b0; ch_ready = 4'b0011;
    step();
    check("s3_inflight_done", 32'(ch_valid), 0);
    bcast_pipe_full = 1'b0;

    // Scenario 4: zero mask is accepted and dropped.
    req_valid = 1'b1; req_mask = 4'b0000; req_pkt = 16'h0099; #1;
    check("s4_req_ready", 32'(req_ready), 1);
    check("s4_mask_err", 32'(mask_err), 1);
    check("s4_bcast_add", 32'(bcast_add), 0);
    step();
    req_valid = 1'b0; #1;
    check("s4_ch_valid", 32'(ch_valid), 0);
    check("s4_busy", 32'(busy), 0);
    check("s4_issued", 32'(issued_cnt), 5);
    check("s4_mask_err_pulse", 32'(mask_err), 0);

    // Scenario 5: stall watchdog with limit 8.
    req_valid = 1'b1; req_mask = 4'b0001; req_pkt = 16'h00C3; ch_ready = 4'b0000;
    step();
    req_valid = 1'b0;
    check("s5_stall_start", 32'(stall_err), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("s5_stall_c%0d", i + 1), 32'(stall_err), (i == 7) ? 1 : 0);
    end
    check("s5_still_valid", 32'(ch_valid), 32'b0001);
    ch_ready = 4'b0001;
    step();
    check("s5_done", 32'(ch_valid), 0);
    check("s5_sticky", 32'(stall_err), 1);
    check("s5_issued", 32'(issued_cnt), 6);

    // Scenario 6: asynchronous reset mid-dispatch.
    req_valid = 1'b1; req_mask = 4'b0110; req_pkt = 16'h00E1; ch_ready = 4'b0000;
    step();
    req_valid = 1'b0;
    check("s6_pending", 32'(ch_valid), 32'b0110);
    #2 rst = 1'b1; #1;
    check("s6_async_ch_valid", 32'(ch_valid), 0);
    check("s6_async_issued", 32'(issued_cnt), 0);
    check("s6_async_stall", 32'(stall_err), 0);
    check("s6_async_busy", 32'(busy), 0);
    #1 rst = 1'b0;
    step();
    req_valid = 1'b1; req_mask = 4'b1011; req_pkt = 16'h00A5; ch_ready = 4'b1111; #1;
    check("s6_add", 32'(bcast_add), 1);
    step();
    check("s6_ch_valid", 32'(ch_valid), 32'b1011);
    check("s6_issued", 32'(issued_cnt), 1);
    req_mask = 4'b0001;

    // Counter wrap: 15 more back-to-back broadcasts take a 4-bit count from 1 to 0.
    for (int i = 0; i < 15; i++) step();
    check("wrap_issued", 32'(issued_cnt), 0);
    req_valid = 1'b0;
    step();
    check("wrap_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
